// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the execute-stage ALU, the control unit and the
// ALU share arbiter.
//  - Datapath and status register widths.
//  - exe_cmd encodings. Several mnemonics alias the same ALU operation,
//    which is why these are plain constants rather than an enum.
//  - Bit positions inside the {N,Z,C,V} status register.
//  - The per-requester operation record used inside the arbiter.
package alu_share_arbiter_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int SR_WIDTH   = 4;

  // exe_cmd encodings as seen by the ALU
  localparam logic [3:0] CMD_NONE = 4'd0;   // ALU default: result 0
  localparam logic [3:0] CMD_MOV  = 4'd1;
  localparam logic [3:0] CMD_ADD  = 4'd2;
  localparam logic [3:0] CMD_ADC  = 4'd3;
  localparam logic [3:0] CMD_SUB  = 4'd4;
  localparam logic [3:0] CMD_SBC  = 4'd5;
  localparam logic [3:0] CMD_AND  = 4'd6;
  localparam logic [3:0] CMD_ORR  = 4'd7;
  localparam logic [3:0] CMD_EOR  = 4'd8;
  localparam logic [3:0] CMD_MVN  = 4'd9;
  localparam logic [3:0] CMD_CMP  = CMD_SUB;  // subtract, flags only
  localparam logic [3:0] CMD_TST  = CMD_AND;  // and, flags only
  localparam logic [3:0] CMD_LDR  = CMD_ADD;  // address = base + offset
  localparam logic [3:0] CMD_STR  = CMD_ADD;

  // Status register bit indices
  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  typedef logic [SR_WIDTH-1:0] sr_t;

  // One pending operation from a requester
  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] val1;
    logic [DATA_WIDTH-1:0] val2;
    logic [3:0]            cmd;
    logic                  s;
  } req_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two ALU requesters (plus the result
// consumer) and the ALU share arbiter.
//  req0_* / req1_* : valid/ready handshake with operands, exe_cmd and the
//                    "update status register" flag s
//  rsp_*           : registered result with valid/ready, owner id and the
//                    flags produced by that operation
// Modports: master = requesters/consumer side, slave = arbiter side.
interface alu_share_arbiter_if
  import alu_share_arbiter_pkg::*;
();

  logic                  req0_valid;
  logic                  req0_ready;
  logic [DATA_WIDTH-1:0] req0_val1;
  logic [DATA_WIDTH-1:0] req0_val2;
  logic [3:0]            req0_cmd;
  logic                  req0_s;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [DATA_WIDTH-1:0] req1_val1;
  logic [DATA_WIDTH-1:0] req1_val2;
  logic [3:0]            req1_cmd;
  logic                  req1_s;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [DATA_WIDTH-1:0] rsp_res;
  sr_t                   rsp_sr;

  modport master (
    output req0_valid, req0_val1, req0_val2, req0_cmd, req0_s,
    input  req0_ready,
    output req1_valid, req1_val1, req1_val2, req1_cmd, req1_s,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_res, rsp_sr,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_val1, req0_val2, req0_cmd, req0_s,
    output req0_ready,
    input  req1_valid, req1_val1, req1_val2, req1_cmd, req1_s,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_res, rsp_sr,
    input  rsp_ready
  );

endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant.
//  req   : request vector, bit N = requester N wants the ALU
//  last  : index of the requester granted most recently
//  grant : one-hot grant (all zero when nothing requests)
// A lone request always wins; on contention the requester that was not
// granted last time wins, so each side waits at most one slot.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares the single combinational execute-stage ALU between the main EXE
// stage (requester 0) and the auxiliary address/compare unit (requester 1).
// Ports:
//  clk, rst        clock and synchronous active-high reset
//  bus (slave)     requester handshakes and registered response
//  alu_val_1/2     operands to the ALU
//  alu_exe_cmd     operation to the ALU (0 when idle)
//  alu_sr_in       status register fed to the ALU (always sr_q)
//  alu_res         result from the ALU
//  alu_sr_out      flags from the ALU
//  sr_q            architectural status register {N,Z,C,V}
// An operation is accepted in the cycle its ready is high; its result and
// flags are captured on that edge and presented as rsp_* one cycle later.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int SR_W   = SR_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  alu_share_arbiter_if.slave bus,
  output logic [DATA_W-1:0] alu_val_1,
  output logic [DATA_W-1:0] alu_val_2,
  output logic [3:0]        alu_exe_cmd,
  output logic [SR_W-1:0]   alu_sr_in,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [SR_W-1:0]   alu_sr_out,
  output logic [SR_W-1:0]   sr_q
);

  req_t              reqs [2];
  logic              can_accept;
  logic [1:0]        arb_req;
  logic [1:0]        arb_grant;
  logic [1:0]        grant;
  logic              accept;
  logic              sel;

  logic              last_reg;
  logic              rsp_valid_reg;
  logic              rsp_id_reg;
  logic [DATA_W-1:0] rsp_res_reg;
  logic [SR_W-1:0]   rsp_sr_reg;
  logic [SR_W-1:0]   sr_reg;

  assign reqs[0] = '{valid: bus.req0_valid, val1: bus.req0_val1,
                     val2: bus.req0_val2, cmd: bus.req0_cmd, s: bus.req0_s};
  assign reqs[1] = '{valid: bus.req1_valid, val1: bus.req1_val1,
                     val2: bus.req1_val2, cmd: bus.req1_cmd, s: bus.req1_s};

  // A held response that is being drained this cycle frees the slot, so a
  // new operation can be accepted in the same cycle.
  assign can_accept = !rsp_valid_reg || bus.rsp_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign arb_req[gi] = reqs[gi].valid && can_accept;
    end
  endgenerate

  rr_arb2 u_rr_arb2 (
    .req   (arb_req),
    .last  (last_reg),
    .grant (arb_grant)
  );

  // No handshake completes while reset is held.
  assign grant  = rst ? 2'b00 : arb_grant;
  assign accept = |grant;
  assign sel    = grant[1];

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  // Idle cycles still present requester 0's operands but with the ALU's
  // default command, so the ALU output settles to 0.
  always_comb begin
    alu_val_1   = reqs[0].val1;
    alu_val_2   = reqs[0].val2;
    alu_exe_cmd = CMD_NONE;
    if (accept) begin
      alu_val_1   = reqs[sel].val1;
      alu_val_2   = reqs[sel].val2;
      alu_exe_cmd = reqs[sel].cmd;
    end
  end

  // Carry-in for ADC/SBC is the status register as it stands at the accept
  // edge; an S-op accepted one cycle earlier has already written it.
  assign alu_sr_in = sr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= 1'b0;
      rsp_res_reg   <= '0;
      rsp_sr_reg    <= '0;
      sr_reg        <= '0;
      last_reg      <= 1'b1;
    end else if (accept) begin
      rsp_valid_reg <= 1'b1;
      rsp_id_reg    <= sel;
      rsp_res_reg   <= alu_res;
      rsp_sr_reg    <= alu_sr_out;
      last_reg      <= sel;
      if (reqs[sel].s) begin
        sr_reg <= alu_sr_out;
      end
    end else if (bus.rsp_ready) begin
      // Drained with nothing to replace it: data fields keep their value.
      rsp_valid_reg <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_res   = rsp_res_reg;
  assign bus.rsp_sr    = rsp_sr_reg;
  assign sr_q          = sr_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] alu_val_1;
  logic [31:0] alu_val_2;
  logic [3:0]  alu_exe_cmd;
  logic [3:0]  alu_sr_in;
  logic [31:0] alu_res;
  logic [3:0]  alu_sr_out;
  logic [3:0]  sr_q;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter_if bus ();

  alu_share_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .alu_val_1   (alu_val_1),
    .alu_val_2   (alu_val_2),
    .alu_exe_cmd (alu_exe_cmd),
    .alu_sr_in   (alu_sr_in),
    .alu_res     (alu_res),
    .alu_sr_out  (alu_sr_out),
    .sr_q        (sr_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: C is the carry out for additions and the borrow for
  // subtractions; unknown commands give res=0 with C=V=0.
  always_comb begin
    logic [32:0] t;
    logic        c;
    logic        v;
    logic [31:0] r;
    t = '0;
    c = 1'b0;
    v = 1'b0;
    r = '0;
    case (alu_exe_cmd)
      4'd1: r = alu_val_2;
      4'd9: r = ~alu_val_2;
      4'd2, 4'd3: begin
        t = {1'b0, alu_val_1} + {1'b0, alu_val_2} +
            {32'd0, (alu_exe_cmd == 4'd3) ? alu_sr_in[1] : 1'b0};
        r = t[31:0];
        c = t[32];
        v = (alu_val_1[31] == alu_val_2[31]) && (r[31] != alu_val_1[31]);
      end
      4'd4, 4'd5: begin
        t = {1'b0, alu_val_1} - {1'b0, alu_val_2} -
            {32'd0, (alu_exe_cmd == 4'd5) ? alu_sr_in[1] : 1'b0};
        r = t[31:0];
        c = t[32];
        v = (alu_val_1[31] != alu_val_2[31]) && (r[31] != alu_val_1[31]);
      end
      4'd6: r = alu_val_1 & alu_val_2;
      4'd7: r = alu_val_1 | alu_val_2;
      4'd8: r = alu_val_1 ^ alu_val_2;
      default: r = '0;
    endcase
    alu_res    = r;
    alu_sr_out = {r[31], (r == 32'd0), c, v};
  end

  typedef struct {
    logic        v0;
    logic [3:0]  c0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic        s0;
    logic        v1;
    logic [3:0]  c1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        s1;
    logic        exp_r0;
    logic        exp_r1;
    logic [3:0]  exp_srin;
    logic        exp_rv;
    logic        exp_id;
    logic [31:0] exp_res;
    logic [3:0]  exp_sr;
    logic [3:0]  exp_srq;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic s);
    bus.req0_valid = v;
    bus.req0_cmd   = c;
    bus.req0_val1  = a;
    bus.req0_val2  = b;
    bus.req0_s     = s;
  endtask

  task automatic drive1(input logic v, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic s);
    bus.req1_valid = v;
    bus.req1_cmd   = c;
    bus.req1_val1  = a;
    bus.req1_val2  = b;
    bus.req1_s     = s;
  endtask

  task automatic check_rsp(input string tag, input logic rv, input logic id,
                           input logic [31:0] res, input logic [3:0] sr,
                           input logic [3:0] srq);
    check({tag, ".rsp_valid"}, {31'd0, bus.rsp_valid}, {31'd0, rv});
    check({tag, ".rsp_id"},    {31'd0, bus.rsp_id},    {31'd0, id});
    check({tag, ".rsp_res"},   bus.rsp_res,            res);
    check({tag, ".rsp_sr"},    {28'd0, bus.rsp_sr},    {28'd0, sr});
    check({tag, ".sr_q"},      {28'd0, sr_q},          {28'd0, srq});
  endtask

  task automatic check_ready(input string tag, input logic r0, input logic r1);
    check({tag, ".req0_ready"}, {31'd0, bus.req0_ready}, {31'd0, r0});
    check({tag, ".req1_ready"}, {31'd0, bus.req1_ready}, {31'd0, r1});
  endtask

  initial begin
    // v0 c0 a0 b0 s0 | v1 c1 a1 b1 s1 | r0 r1 srin | rv id res sr srq
    vecs[0] = '{1, CMD_ADD, 32'd5, 32'd7, 1,  0, CMD_NONE, 32'd0, 32'd0, 0,
                1, 0, 4'b0000,  1, 0, 32'd12, 4'b0000, 4'b0000};
    vecs[1] = '{1, CMD_MOV, 32'd0, 32'd1, 0,  1, CMD_ADD, 32'd1, 32'd2, 0,
                0, 1, 4'b0000,  1, 1, 32'd3, 4'b0000, 4'b0000};
    vecs[2] = '{1, CMD_SUB, 32'd3, 32'd3, 1,  1, CMD_ADC, 32'd1, 32'd1, 1,
                1, 0, 4'b0000,  1, 0, 32'd0, 4'b0100, 4'b0100};
    vecs[3] = '{0, CMD_NONE, 32'd0, 32'd0, 0,  1, CMD_ADC, 32'd1, 32'd1, 0,
                0, 1, 4'b0100,  1, 1, 32'd2, 4'b0000, 4'b0100};
    vecs[4] = '{0, CMD_NONE, 32'd0, 32'd0, 0,  1, CMD_MOV, 32'd0, 32'hFFFF_FFFF, 0,
                0, 1, 4'b0100,  1, 1, 32'hFFFF_FFFF, 4'b1000, 4'b0100};
    vecs[5] = '{1, CMD_SUB, 32'd1, 32'd2, 1,  0, CMD_NONE, 32'd0, 32'd0, 0,
                1, 0, 4'b0100,  1, 0, 32'hFFFF_FFFF, 4'b1010, 4'b1010};
    vecs[6] = '{1, 4'hF, 32'd9, 32'd9, 1,  0, CMD_NONE, 32'd0, 32'd0, 0,
                1, 0, 4'b1010,  1, 0, 32'd0, 4'b0100, 4'b0100};
    vecs[7] = '{0, CMD_NONE, 32'd0, 32'd0, 0,  0, CMD_NONE, 32'd0, 32'd0, 0,
                0, 0, 4'b0100,  0, 0, 32'd0, 4'b0100, 4'b0100};
    vecs[8] = '{1, CMD_EOR, 32'hF0, 32'hFF, 0,  1, CMD_ORR, 32'd1, 32'd2, 1,
                0, 1, 4'b0100,  1, 1, 32'd3, 4'b0000, 4'b0000};
    vecs[9] = '{1, CMD_EOR, 32'hF0, 32'hFF, 0,  0, CMD_NONE, 32'd0, 32'd0, 0,
                1, 0, 4'b0000,  1, 0, 32'h0F, 4'b0000, 4'b0000};

    // Reset with both requesters asking: nothing may be accepted.
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    drive0(1, CMD_ADD, 32'd1, 32'd1, 1);
    drive1(1, CMD_ADD, 32'd2, 32'd2, 1);
    tick();
    #3;
    check_ready("reset", 0, 0);
    tick();
    check_rsp("reset", 0, 0, 32'd0, 4'b0000, 4'b0000);
    rst = 1'b0;
    drive0(0, CMD_NONE, 32'd0, 32'd0, 0);
    drive1(0, CMD_NONE, 32'd0, 32'd0, 0);
    tick();

    // Table of single-cycle transactions, rsp_ready held high.
    for (int i = 0; i < 10; i++) begin
      drive0(vecs[i].v0, vecs[i].c0, vecs[i].a0, vecs[i].b0, vecs[i].s0);
      drive1(vecs[i].v1, vecs[i].c1, vecs[i].a1, vecs[i].b1, vecs[i].s1);
      #3;
      check_ready($sformatf("vec%0d", i), vecs[i].exp_r0, vecs[i].exp_r1);
      check($sformatf("vec%0d.alu_sr_in", i), {28'd0, alu_sr_in}, {28'd0, vecs[i].exp_srin});
      tick();
      check_rsp($sformatf("vec%0d", i), vecs[i].exp_rv, vecs[i].exp_id,
                vecs[i].exp_res, vecs[i].exp_sr, vecs[i].exp_srq);
      $display("vec %0d: ready=%b%b rsp_valid=%b id=%0d res=%h sr=%b sr_q=%b",
               i, vecs[i].exp_r0, vecs[i].exp_r1, bus.rsp_valid, bus.rsp_id,
               bus.rsp_res, bus.rsp_sr, sr_q);
    end

    // Backpressure: response held, no accepts, then release refills at once.
    drive0(1, CMD_ADD, 32'd2, 32'd2, 0);
    drive1(0, CMD_NONE, 32'd0, 32'd0, 0);
    #3;
    check_ready("bp_fill", 1, 0);
    tick();
    check_rsp("bp_fill", 1, 0, 32'd4, 4'b0000, 4'b0000);
    $display("bp fill: rsp id=%0d res=%h", bus.rsp_id, bus.rsp_res);
    bus.rsp_ready = 1'b0;
    drive0(1, CMD_ADD, 32'd10, 32'd1, 0);
    drive1(1, CMD_SUB, 32'd20, 32'd21, 1);
    for (int k = 0; k < 2; k++) begin
      #3;
      check_ready($sformatf("bp_hold%0d", k), 0, 0);
      check($sformatf("bp_hold%0d.alu_exe_cmd", k), {28'd0, alu_exe_cmd}, 32'd0);
      tick();
      check_rsp($sformatf("bp_hold%0d", k), 1, 0, 32'd4, 4'b0000, 4'b0000);
      $display("bp hold %0d: rsp id=%0d res=%h", k, bus.rsp_id, bus.rsp_res);
    end
    bus.rsp_ready = 1'b1;
    #3;
    check_ready("bp_release", 0, 1);
    tick();
    check_rsp("bp_release", 1, 1, 32'hFFFF_FFFF, 4'b1010, 4'b1010);
    $display("bp release: rsp id=%0d res=%h sr_q=%b", bus.rsp_id, bus.rsp_res, sr_q);

    // Reset while a response is held and both sides are requesting.
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    #3;
    check_ready("midrst", 0, 0);
    tick();
    check_rsp("midrst", 0, 0, 32'd0, 4'b0000, 4'b0000);
    $display("mid reset: rsp_valid=%b sr_q=%b", bus.rsp_valid, sr_q);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;

    // Both valid every cycle: grants alternate starting with requester 0.
    for (int k = 0; k < 4; k++) begin
      drive0(1, CMD_ADD, k, 32'd100, 0);
      drive1(1, CMD_ADD, k, 32'd200, 0);
      #3;
      check_ready($sformatf("alt%0d", k), (k % 2) == 0, (k % 2) == 1);
      tick();
      check_rsp($sformatf("alt%0d", k), 1, (k % 2) == 1,
                k + (((k % 2) == 0) ? 100 : 200), 4'b0000, 4'b0000);
      $display("alt %0d: rsp id=%0d res=%h", k, bus.rsp_id, bus.rsp_res);
    end

    drive0(0, CMD_NONE, 32'd0, 32'd0, 0);
    drive1(0, CMD_NONE, 32'd0, 32'd0, 0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
